// File: rtl/bypass_pipe.sv
// ============================================================================
// Module   : bypass_pipe
// Purpose  : Writeback pipeline with combinational operand forwarding.
//            Define BYPASS_FROM_IN_EN to also forward from the incoming result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bypass_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int STAGES = 2,   // legal range 1..8
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  in_wreg_i,
  input  logic [ADDR_W-1:0]     in_wd_i,
  input  logic [DATA_W-1:0]     in_wdata_i,
  input  logic [NRD-1:0]        rd_re_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  input  logic [NRD*DATA_W-1:0] rf_data_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_hit_o,
  output logic                  wb_wreg_o,
  output logic [ADDR_W-1:0]     wb_wd_o,
  output logic [DATA_W-1:0]     wb_wdata_o,
  output logic [3:0]            occ_o
);

  logic [STAGES-1:0] r_wreg;
  logic [ADDR_W-1:0] r_wd    [STAGES];
  logic [DATA_W-1:0] r_wdata [STAGES];
  logic [3:0]        r_occ;

  logic [STAGES-1:0] w_wreg_nxt;
  logic [ADDR_W-1:0] w_wd_nxt    [STAGES];
  logic [DATA_W-1:0] w_wdata_nxt [STAGES];
  logic [3:0]        w_occ_nxt;

  // Next-state of the shift chain; occupancy is counted from it so occ_o is registered.
  always_comb begin
    w_wreg_nxt  = r_wreg;
    w_wd_nxt    = r_wd;
    w_wdata_nxt = r_wdata;
    if (flush_i) begin
      w_wreg_nxt = '0;
      for (int s = 0; s < STAGES; s++) begin
        w_wd_nxt[s]    = '0;
        w_wdata_nxt[s] = '0;
      end
    end else if (!stall_i) begin
      w_wreg_nxt[0]  = in_wreg_i;
      w_wd_nxt[0]    = in_wd_i;
      w_wdata_nxt[0] = in_wdata_i;
      for (int s = 1; s < STAGES; s++) begin
        w_wreg_nxt[s]  = r_wreg[s-1];
        w_wd_nxt[s]    = r_wd[s-1];
        w_wdata_nxt[s] = r_wdata[s-1];
      end
    end
    w_occ_nxt = '0;
    for (int s = 0; s < STAGES; s++) begin
      w_occ_nxt = w_occ_nxt + {3'b000, w_wreg_nxt[s]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wreg <= '0;
      r_occ  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_wd[s]    <= '0;
        r_wdata[s] <= '0;
      end
    end else begin
      r_wreg  <= w_wreg_nxt;
      r_wd    <= w_wd_nxt;
      r_wdata <= w_wdata_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  // Oldest source first so that younger matches overwrite older ones.
  always_comb begin
    rd_data_o = '0;
    rd_hit_o  = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rd_re_i[p] && (rd_addr_i[p*ADDR_W +: ADDR_W] != '0)) begin
        rd_data_o[p*DATA_W +: DATA_W] = rf_data_i[p*DATA_W +: DATA_W];
        for (int s = STAGES - 1; s >= 0; s--) begin
          if (r_wreg[s] && (r_wd[s] == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
            rd_data_o[p*DATA_W +: DATA_W] = r_wdata[s];
            rd_hit_o[p]                   = 1'b1;
          end
        end
`ifdef BYPASS_FROM_IN_EN
        if (in_wreg_i && (in_wd_i == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
          rd_data_o[p*DATA_W +: DATA_W] = in_wdata_i;
          rd_hit_o[p]                   = 1'b1;
        end
`endif
      end
    end
  end

  // A stalled retiring entry is written once, on the cycle the stall releases.
  assign wb_wreg_o  = r_wreg[STAGES-1] & ~stall_i;
  assign wb_wd_o    = r_wd[STAGES-1];
  assign wb_wdata_o = r_wdata[STAGES-1];
  assign occ_o      = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_bypass_pipe.sv
// ============================================================================
// Module   : tb_bypass_pipe
// Purpose  : Randomized and directed checks of bypass_pipe against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bypass_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STAGES = 2;
  localparam int NRD    = 2;
`ifdef BYPASS_FROM_IN_EN
  localparam bit IN_FWD = 1'b1;
`else
  localparam bit IN_FWD = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall, flush;
  logic                  in_wreg;
  logic [ADDR_W-1:0]     in_wd;
  logic [DATA_W-1:0]     in_wdata;
  logic [NRD-1:0]        rd_re;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rf_data;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_hit;
  logic                  wb_wreg;
  logic [ADDR_W-1:0]     wb_wd;
  logic [DATA_W-1:0]     wb_wdata;
  logic [3:0]            occ;

  bypass_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGES(STAGES), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .in_wreg_i(in_wreg), .in_wd_i(in_wd), .in_wdata_i(in_wdata),
    .rd_re_i(rd_re), .rd_addr_i(rd_addr), .rf_data_i(rf_data),
    .rd_data_o(rd_data), .rd_hit_o(rd_hit),
    .wb_wreg_o(wb_wreg), .wb_wd_o(wb_wd), .wb_wdata_o(wb_wdata), .occ_o(occ)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] wd;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t pipe[$];   // pipe[0] is the youngest stored entry
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    pipe = {};
    for (int s = 0; s < STAGES; s++) pipe.push_back('0);
  endtask

  task automatic model_edge();
    ent_t e;
    if (flush) begin
      model_clear();
    end else if (!stall) begin
      e.v = in_wreg; e.wd = in_wd; e.d = in_wdata;
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    foreach (pipe[i]) if (pipe[i].v) n++;
    return n;
  endfunction

  // Youngest-first search for a matching writer.
  task automatic exp_rd(input int p, output logic [DATA_W-1:0] d, output logic h);
    logic [ADDR_W-1:0] a;
    a = rd_addr[p*ADDR_W +: ADDR_W];
    d = '0; h = 1'b0;
    if (rd_re[p] && a != 0) begin
      d = rf_data[p*DATA_W +: DATA_W];
      if (IN_FWD && in_wreg && in_wd == a) begin
        d = in_wdata; h = 1'b1;
      end else begin
        for (int i = 0; i < STAGES; i++) begin
          if (pipe[i].v && pipe[i].wd == a) begin
            d = pipe[i].d; h = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic check_comb();
    logic [DATA_W-1:0] ed;
    logic              eh;
    for (int p = 0; p < NRD; p++) begin
      exp_rd(p, ed, eh);
      chk($sformatf("rd_data%0d", p), 64'(rd_data[p*DATA_W +: DATA_W]), 64'(ed));
      chk($sformatf("rd_hit%0d", p), 64'(rd_hit[p]), 64'(eh));
    end
    chk("wb_wreg", 64'(wb_wreg), 64'(pipe[STAGES-1].v && !stall));
    chk("wb_wd", 64'(wb_wd), 64'(pipe[STAGES-1].wd));
    chk("wb_wdata", 64'(wb_wdata), 64'(pipe[STAGES-1].d));
    chk("occ", 64'(occ), 64'(model_occ()));
  endtask

  // Inputs are set at the falling edge; this checks, clocks, and returns at the next falling edge.
  task automatic step();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_comb();
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic fl, input logic w,
                       input int wd, input logic [DATA_W-1:0] wdat);
    stall = st; flush = fl; in_wreg = w;
    in_wd = ADDR_W'(wd); in_wdata = wdat;
  endtask

  task automatic reads(input logic [1:0] re, input int a0, input int a1);
    rd_re = re;
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    rf_data = {$urandom(), $urandom()};
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, '0);
    reads(2'b11, 1, 2);
    model_clear();
    @(negedge clk);
    #1 check_comb();
    rst = 1'b0;

    // single result through a 2-deep pipe
    drive(0, 0, 1, 3, 32'h11);
    step();
    chk("lat_occ_e1", 64'(occ), 64'd1);
    chk("lat_wb_c1", 64'(wb_wreg), 64'd0);
    drive(0, 0, 0, 0, '0);
    step();
    chk("lat_occ_e2", 64'(occ), 64'd1);
    chk("lat_wb_c2", {31'd0, wb_wreg, 27'(wb_wd), wb_wdata}, {31'd0, 1'b1, 27'd3, 32'h11});
    step();
    chk("lat_wb_c3", 64'(wb_wreg), 64'd0);

    // youngest-match priority
    drive(0, 0, 1, 5, 32'hB); step();
    drive(0, 0, 1, 5, 32'hA); step();
    drive(0, 0, 1, 5, 32'hC); reads(2'b01, 5, 0);
    #1 chk("prio_data", 64'(rd_data[DATA_W-1:0]), IN_FWD ? 64'hC : 64'hA);
    chk("prio_hit", 64'(rd_hit[0]), 64'd1);
    step();

    // r0 and disabled ports
    drive(0, 0, 1, 0, 32'hFF); reads(2'b01, 0, 5);
    #1 chk("r0_port", {rd_hit, rd_data}, '0);
    step();

    // stall with last stage valid
    drive(0, 0, 1, 9, 32'h99); step();
    drive(0, 0, 1, 10, 32'h1010); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 7, 32'h77);
      #1 chk("stall_wb", 64'(wb_wreg), 64'd0);
      step();
    end
    drive(0, 0, 0, 0, '0);
    #1 chk("release_wb", {31'd0, wb_wreg, 27'(wb_wd), wb_wdata}, {31'd0, 1'b1, 27'd9, 32'h99});
    step();

    // flush beats stall
    drive(0, 0, 1, 11, 32'hAA); step();
    drive(1, 1, 1, 12, 32'hBB); step();
    chk("flush_occ", 64'(occ), 64'd0);
    drive(0, 0, 0, 0, '0); reads(2'b11, 11, 10);
    #1 chk("flush_rd", {rd_hit, rd_data}, {2'b00, rf_data});
    step();

    // asynchronous reset between edges with a full pipe
    drive(0, 0, 1, 4, 32'h44); step();
    drive(0, 0, 1, 6, 32'h66); step();
    drive(1, 1, 0, 0, '0);
    rst = 1'b1;
    #1 chk("arst_out", {27'd0, occ, wb_wreg, 27'(wb_wd), wb_wdata}, '0);
    model_clear();
    rst = 1'b0;
    drive(0, 0, 0, 0, '0);
    step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom());
      reads(2'($urandom()), $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
